// File: rtl/id_inst_buffer_pkg.sv
// Shared constants for the IF->ID instruction buffer.
// Entry layout is {pc, inst}, pc in the upper bits.
package id_inst_buffer_pkg;

  localparam int IBUF_DEFAULT_DEPTH = 4;
  localparam int IBUF_PC_WD         = 32;
  localparam int IBUF_INST_WD       = 32;
  localparam int IBUF_ENTRY_WD      = IBUF_PC_WD + IBUF_INST_WD;

endpackage : id_inst_buffer_pkg

// File: rtl/id_inst_buffer_fifo.sv
// Storage for the instruction buffer: a DEPTH-entry circular queue.
// It holds the data array, the read/write pointers and the entry count.
// clear_i empties the queue by snapping rd_ptr to wr_ptr and takes priority.
// The caller must never push when the queue is full or pop when it is empty.
module ibuf_fifo
  import id_inst_buffer_pkg::*;
#(
  parameter int DEPTH   = IBUF_DEFAULT_DEPTH,
  parameter int DATA_WD = IBUF_ENTRY_WD
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [DATA_WD-1:0]       wdata_i,
  output logic [DATA_WD-1:0]       head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_WD = $clog2(DEPTH);
  localparam int CNT_WD = PTR_WD + 1;

  logic [DATA_WD-1:0] mem_q [DEPTH];
  logic [PTR_WD-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_WD-1:0]  count_q, count_d;

  // Next-state for pointers and count; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i) count_d = count_q + 1'b1;
      else if (pop_i && !push_i) count_d = count_q - 1'b1;
    end
  end

  // Pointer and count registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data array: written on push only, no reset needed on payload.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : ibuf_fifo

// File: rtl/id_inst_buffer.sv
// IF->ID instruction buffer. Pairs each accepted fetch PC with the SRAM
// data returning one cycle later and queues the pair for ID.
// Optional macro IBUF_BYPASS_EN: when the queue is empty, the completing
// fetch is presented to ID in the same cycle (1-cycle issue-to-valid).
// Backpressure counts the in-flight fetch but never credits pops, so the
// queue cannot overflow regardless of what ID does in the same cycle.
module id_inst_buffer
  import id_inst_buffer_pkg::*;
#(
  parameter int DEPTH   = IBUF_DEFAULT_DEPTH,
  parameter int PC_WD   = IBUF_PC_WD,
  parameter int INST_WD = IBUF_INST_WD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [PC_WD-1:0]       if_pc,
  output logic                   if_ready,
  input  logic [INST_WD-1:0]     inst_sram_rdata,
  input  logic                   flush,
  output logic                   id_valid,
  output logic [PC_WD-1:0]       id_pc,
  output logic [INST_WD-1:0]     id_inst,
  input  logic                   id_ready,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CNT_WD   = $clog2(DEPTH) + 1;
  localparam int ENTRY_WD = PC_WD + INST_WD;

  logic                pend_v_q, pend_v_d;
  logic [PC_WD-1:0]    pend_pc_q, pend_pc_d;
  logic [CNT_WD-1:0]   fifo_count;
  logic [ENTRY_WD-1:0] fifo_head;
  logic [CNT_WD:0]     inflight;
  logic                fifo_has, fetch_accept, complete, byp;
  logic                fifo_push, fifo_pop;

  assign fifo_has     = (fifo_count != '0);
  assign inflight     = {1'b0, fifo_count} + {{CNT_WD{1'b0}}, pend_v_q};
  assign if_ready     = (inflight <= (CNT_WD+1)'(DEPTH - 1));
  assign fetch_accept = if_valid & if_ready & ~flush;
  assign complete     = pend_v_q & ~flush;

`ifdef IBUF_BYPASS_EN
  assign byp = ~fifo_has & pend_v_q & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign id_valid  = (fifo_has | byp) & ~flush;
  // A bypassed entry that ID takes immediately never enters storage.
  assign fifo_push = complete & ~(byp & id_ready);
  assign fifo_pop  = fifo_has & ~flush & id_ready;

  // Head mux; outputs are forced to zero when nothing valid is presented.
  always_comb begin
    id_pc   = '0;
    id_inst = '0;
    if (id_valid) begin
      if (byp) begin
        id_pc   = pend_pc_q;
        id_inst = inst_sram_rdata;
      end else begin
        id_pc   = fifo_head[ENTRY_WD-1:INST_WD];
        id_inst = fifo_head[INST_WD-1:0];
      end
    end
  end

  // Pending-fetch tracking: a fetch is outstanding for exactly one cycle.
  always_comb begin
    pend_v_d  = fetch_accept;
    pend_pc_d = fetch_accept ? if_pc : pend_pc_q;
  end

  // Pending-fetch registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  ibuf_fifo #(
    .DEPTH   (DEPTH),
    .DATA_WD (ENTRY_WD)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (flush),
    .wdata_i ({pend_pc_q, inst_sram_rdata}),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign occupancy = fifo_count;

endmodule : id_inst_buffer

// File: tb/tb_id_inst_buffer.sv
// Randomized scoreboard bench for id_inst_buffer (DEPTH=4).
// The reference model is a queue of every fetch that has been accepted and
// not yet consumed (the last one possibly still pending on the SRAM).
module tb_id_inst_buffer;

  localparam int DEPTH   = 4;
  localparam int PC_WD   = 32;
  localparam int INST_WD = 32;
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               if_valid = 1'b0;
  logic [PC_WD-1:0]   if_pc = '0;
  logic               if_ready;
  logic [INST_WD-1:0] inst_sram_rdata = '0;
  logic               flush = 1'b0;
  logic               id_valid;
  logic [PC_WD-1:0]   id_pc;
  logic [INST_WD-1:0] id_inst;
  logic               id_ready = 1'b0;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  id_inst_buffer #(.DEPTH(DEPTH), .PC_WD(PC_WD), .INST_WD(INST_WD)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
    .if_ready(if_ready), .inst_sram_rdata(inst_sram_rdata), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_ready(id_ready), .occupancy(occupancy)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        exp_q[$];
  bit          pend = 1'b0;
  logic [31:0] pend_inst = '0;
  bit          mon_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks outputs mid-cycle against the model, pops on transfer.
  always @(negedge clk) begin : mon
    int stored;
    bit ev;
    if (mon_en) begin
      stored = exp_q.size() - int'(pend);
      ev = !flush && (stored > 0 || (BYP && pend));
      chk("occupancy", 64'(occupancy), 64'(stored));
      chk("if_ready", 64'(if_ready), 64'(exp_q.size() <= DEPTH - 1));
      chk("id_valid", 64'(id_valid), 64'(ev));
      if (ev && id_valid) begin
        chk("id_pc", 64'(id_pc), 64'(exp_q[0].pc));
        chk("id_inst", 64'(id_inst), 64'(exp_q[0].inst));
      end
      if (ev && id_ready) begin
        $display("txn pc=%h inst=%h", exp_q[0].pc, exp_q[0].inst);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; inst is the SRAM data returned for this fetch.
  task automatic do_cycle(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                          input bit rdy, input bit fl);
    bit   room;
    ent_t e;
    if_valid = v;
    if_pc    = pc;
    id_ready = rdy;
    flush    = fl;
    inst_sram_rdata = pend ? pend_inst : $urandom;
    room = (exp_q.size() <= DEPTH - 1);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      pend = 1'b0;
    end else begin
      pend = v && room;
      if (pend) begin
        e.pc = pc;
        e.inst = inst;
        exp_q.push_back(e);
        pend_inst = inst;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] pc;
    // Reset state while rst is held.
    #12;
    chk("rst_id_valid", 64'(id_valid), 64'(0));
    chk("rst_id_pc", 64'(id_pc), 64'(0));
    chk("rst_id_inst", 64'(id_inst), 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_if_ready", 64'(if_ready), 64'(1));
    mon_en = 1'b1;

    // Streaming.
    do_cycle(1, 32'hBFC00000, 32'h3C010001, 1, 0);
    do_cycle(1, 32'hBFC00004, 32'h34210002, 1, 0);
    do_cycle(1, 32'hBFC00008, 32'h00000000, 1, 0);
    idle(3);

    // Fill with ID stalled, then drain.
    for (int i = 0; i < 7; i++) do_cycle(1, 32'hBFC00200 + 32'(4*i), $urandom, 0, 0);
    idle(6);

    // Wrap with head alternately stalled.
    for (int i = 0; i < 11; i++) do_cycle(1, 32'hBFC00300 + 32'(4*i), $urandom, i[0], 0);
    idle(8);

    // Flush with 3 queued plus one pending, then a fresh fetch.
    for (int i = 0; i < 4; i++) do_cycle(1, 32'hBFC00400 + 32'(4*i), $urandom, 0, 0);
    do_cycle(0, 32'h0, 32'h0, 0, 1);
    do_cycle(1, 32'hBFC00100, 32'h24020005, 1, 0);
    idle(3);

    // Fetch presented in the flush cycle is dropped.
    do_cycle(1, 32'hBFC00500, 32'h11111111, 1, 1);
    idle(3);

    // Randomized traffic.
    pc = 32'hBFC01000;
    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 3) != 0, pc, $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      pc = pc + 32'd4;
    end

    // Asynchronous reset mid-stream, asserted between edges.
    for (int i = 0; i < 3; i++) do_cycle(1, 32'hBFC02000 + 32'(4*i), $urandom, 0, 0);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_id_valid", 64'(id_valid), 64'(0));
    chk("arst_id_pc", 64'(id_pc), 64'(0));
    chk("arst_id_inst", 64'(id_inst), 64'(0));
    chk("arst_occupancy", 64'(occupancy), 64'(0));
    if_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    exp_q.delete();
    pend = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_rel_if_ready", 64'(if_ready), 64'(1));
    chk("arst_rel_occupancy", 64'(occupancy), 64'(0));
    mon_en = 1'b1;
    do_cycle(1, 32'hBFC03000, 32'hDEADBEEF, 1, 0);
    do_cycle(1, 32'hBFC03004, 32'hCAFEF00D, 1, 0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_id_inst_buffer
